iod_delay_line_ctrl: RTL and testbench
======================================

Name: iod_delay_line_ctrl

Overview:
- Sequencer for the IOD per-lane dynamic delay line (DELAY_LINE_MOVE/DIRECTION/LOAD, DELAY_LINE_OUT_OF_RANGE) used by the DDR3 PHY lanes.
- Accepts tap commands (load, step up N, step down N) over a valid/ready interface from the training logic.
- Generates correctly spaced single-cycle MOVE pulses with stable DIRECTION.
- Tracks the current tap position, saturates at the line limits and reports out-of-range.

Parameters:
- TAP_W, 8, width of tap position and step count.
- MAX_TAP, 255, highest legal tap index.
- LOAD_TAP, 1, tap position restored by a LOAD (matches the static delay value).
- SETTLE_CYCLES, 4, idle cycles after each MOVE/LOAD pulse before the next action (range 1..15).

Ports:
- FAB_CLK  in  1  fabric clock; all logic on rising edge.
- ARST_N  in  1  asynchronous active-low reset.
- CMD_VALID  in  1  command valid.
- CMD_READY  out  1  controller can accept a command.
- CMD_OP  in  2  00 NOP, 01 LOAD, 10 INC, 11 DEC.
- CMD_COUNT  in  TAP_W  number of taps to step (INC/DEC only).
- DONE  out  1  one-cycle completion pulse.
- DONE_OOR  out  1  valid with DONE; 1 = stopped on a range limit.
- TAP_POS  out  TAP_W  current tracked tap position.
- BUSY  out  1  command in progress.
- DELAY_LINE_MOVE  out  1  to IOD, one-cycle step pulse.
- DELAY_LINE_DIRECTION  out  1  to IOD, 1 = increment.
- DELAY_LINE_LOAD  out  1  to IOD, one-cycle reload pulse.
- DELAY_LINE_OUT_OF_RANGE  in  1  from IOD.

Behaviour:
- Reset values: CMD_READY=0 during reset, then 1 in IDLE; DONE=0, DONE_OOR=0, BUSY=0, MOVE=0, LOAD=0, DIRECTION=0, TAP_POS=LOAD_TAP.
- States and transitions:
  - IDLE: CMD_READY=1, BUSY=0. Accept on CMD_VALID&CMD_READY, capturing op, count and direction.
    - NOP, or INC/DEC with count=0 -> DONE.
    - LOAD -> LOAD.
    - INC/DEC with count>0 -> SETUP.
  - LOAD: LOAD=1 for one cycle; TAP_POS<=LOAD_TAP -> SETTLE.
  - SETUP: one cycle; DIRECTION driven from op and held until the next accepted command -> CHECK.
  - CHECK: limit test. INC with TAP_POS==MAX_TAP, DEC with TAP_POS==0, or a registered OOR flag set -> DONE with DONE_OOR=1 and no pulse; otherwise -> MOVE.
  - MOVE: MOVE=1 for one cycle; TAP_POS+/-1; remaining-1 -> SETTLE.
  - SETTLE: wait SETTLE_CYCLES cycles. On the last cycle, sample DELAY_LINE_OUT_OF_RANGE into the OOR flag. Then -> DONE if remaining==0 or the previous op was LOAD, else -> CHECK.
  - DONE: DONE=1 for one cycle, DONE_OOR=OOR flag -> IDLE. The OOR flag clears on the next accept.
- Timing and handshake:
  - CMD_READY=0 in every state except IDLE; BUSY=~CMD_READY after reset.
  - Latency from accept:
    - NOP: 1 cycle to DONE.
    - LOAD: 1+SETTLE_CYCLES+1.
    - INC/DEC of N taps with no limit hit: 1+N*(2+SETTLE_CYCLES)+1 cycles to DONE.
  - MOVE and LOAD are never asserted in the same cycle.
  - MOVE pulses are separated by at least SETTLE_CYCLES+1 low cycles.
- Arithmetic: TAP_POS never wraps. It is clamped by CHECK, so it never exceeds MAX_TAP or goes below 0.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). Any partial step sequence is abandoned; TAP_POS=LOAD_TAP. The training logic must issue LOAD after reset.
- DELAY_LINE_OUT_OF_RANGE asserted outside SETTLE sampling is ignored.

Optional Feature:
- Macro: IOD_DLY_OOR_SYNC_EN.
- Defined:
  - DELAY_LINE_OUT_OF_RANGE passes through a 2-flop synchronizer (reset to 0) before sampling.
  - SETTLE extends by 2 cycles.
  - INC/DEC latency becomes 1+N*(4+SETTLE_CYCLES)+1.
- Undefined: sampled directly; latencies as in Behaviour.

Decomposition:
- Package iod_dly_pkg: op encoding constants (OP_NOP/OP_LOAD/OP_INC/OP_DEC), FSM state enum (IDLE, LOAD, SETUP, CHECK, MOVE, SETTLE, DONE), settle counter width constant (4).
- Sub-module iod_dly_sync: 2-flop synchronizer with async active-low reset, instantiated only under IOD_DLY_OOR_SYNC_EN.

Test Plan:
- Reset then LOAD -> LOAD pulse 1 cycle after accept; DONE 6 cycles after accept (SETTLE=4); TAP_POS=1; DONE_OOR=0.
- INC count=3 from TAP_POS=1 -> exactly 3 MOVE pulses, DIRECTION=1 throughout, pulses 6 cycles apart; TAP_POS=4; DONE at accept+20.
- TAP_POS=2, DEC count=5 -> 2 MOVE pulses; TAP_POS=0; DONE with DONE_OOR=1; no third pulse.
- INC count=10 with DELAY_LINE_OUT_OF_RANGE forced high during the 4th SETTLE -> 4 pulses; DONE_OOR=1; TAP_POS advanced by 4.
- CMD_VALID held high during an active INC -> CMD_READY=0, second command not accepted until the cycle after DONE. NOP -> DONE 1 cycle after accept, no MOVE/LOAD.
- ARST_N low mid-sequence after the 2nd of 5 pulses -> MOVE=0, BUSY=0, TAP_POS=1 immediately; after release CMD_READY=1 and a new LOAD completes normally.

Source files
------------

// File: rtl/iod_dly_pkg.sv
// Shared encodings for the IOD delay-line controller: command opcodes, FSM states,
// and the settle counter width.
package iod_dly_pkg;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_INC  = 2'b10;
    localparam logic [1:0] OP_DEC  = 2'b11;

    localparam int SETTLE_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETUP,
        CHECK,
        MOVE,
        SETTLE,
        DONE
    } state_e;

endpackage

// File: rtl/iod_delay_line_ctrl_if.sv
// Command/status bundle between the training logic (master) and the delay-line
// controller (slave).
interface iod_delay_line_ctrl_if #(
    parameter int TAP_W = 8
);
    logic             CMD_VALID;
    logic             CMD_READY;
    logic [1:0]       CMD_OP;
    logic [TAP_W-1:0] CMD_COUNT;
    logic             DONE;
    logic             DONE_OOR;
    logic [TAP_W-1:0] TAP_POS;
    logic             BUSY;

    modport master (
        output CMD_VALID, CMD_OP, CMD_COUNT,
        input  CMD_READY, DONE, DONE_OOR, TAP_POS, BUSY
    );

    modport slave (
        input  CMD_VALID, CMD_OP, CMD_COUNT,
        output CMD_READY, DONE, DONE_OOR, TAP_POS, BUSY
    );
endinterface

// File: rtl/iod_dly_sync.sv
// Two-flop synchronizer for DELAY_LINE_OUT_OF_RANGE; only built when
// IOD_DLY_OOR_SYNC_EN is defined, since nothing else instantiates it.
`ifdef IOD_DLY_OOR_SYNC_EN
module iod_dly_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], d};
        end
    end

    assign q = sync_q[1];
endmodule
`endif

// File: rtl/iod_delay_line_ctrl.sv
// IOD per-lane delay-line sequencer: turns LOAD/INC/DEC commands into spaced MOVE/LOAD pulses.
// Optional IOD_DLY_OOR_SYNC_EN: synchronise DELAY_LINE_OUT_OF_RANGE and extend SETTLE by 2 cycles.
module iod_delay_line_ctrl
    import iod_dly_pkg::*;
#(
    parameter int TAP_W         = 8,
    parameter int MAX_TAP       = 255,
    parameter int LOAD_TAP      = 1,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 FAB_CLK,
    input  logic                 ARST_N,
    iod_delay_line_ctrl_if.slave cmd_if,
    output logic                 DELAY_LINE_MOVE,
    output logic                 DELAY_LINE_DIRECTION,
    output logic                 DELAY_LINE_LOAD,
    input  logic                 DELAY_LINE_OUT_OF_RANGE
);

`ifdef IOD_DLY_OOR_SYNC_EN
    localparam int SETTLE_TOTAL = SETTLE_CYCLES + 2;
`else
    localparam int SETTLE_TOTAL = SETTLE_CYCLES;
`endif
    // One spare bit so the synchronizer extension of a 15-cycle settle still fits.
    localparam int                CNT_W       = SETTLE_CNT_W + 1;
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_TOTAL - 1);
    localparam logic [TAP_W-1:0]  MAX_TAP_V   = TAP_W'(MAX_TAP);
    localparam logic [TAP_W-1:0]  LOAD_TAP_V  = TAP_W'(LOAD_TAP);

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [TAP_W-1:0]   rem_q, rem_d;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic               oor_q, oor_d;
    logic               move_q, move_d;
    logic               load_q, load_d;
    logic               done_q, done_d;
    logic               done_oor_q, done_oor_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               oor_smp;
    logic               at_limit;

`ifdef IOD_DLY_OOR_SYNC_EN
    iod_dly_sync u_oor_sync (
        .clk   (FAB_CLK),
        .rst_n (ARST_N),
        .d     (DELAY_LINE_OUT_OF_RANGE),
        .q     (oor_smp)
    );
`else
    assign oor_smp = DELAY_LINE_OUT_OF_RANGE;
`endif

    assign at_limit = dir_q ? (tap_q == MAX_TAP_V) : (tap_q == '0);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        op_d    = op_q;
        rem_d   = rem_q;
        tap_d   = tap_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        oor_d   = oor_q;

        case (state_q)
            IDLE: begin
                if (cmd_if.CMD_VALID && ready_q) begin
                    op_d  = cmd_if.CMD_OP;
                    rem_d = cmd_if.CMD_COUNT;
                    oor_d = 1'b0;
                    if (cmd_if.CMD_OP == OP_LOAD) begin
                        tap_d   = LOAD_TAP_V;
                        state_d = LOAD;
                    end else if (cmd_if.CMD_OP == OP_NOP || cmd_if.CMD_COUNT == '0) begin
                        state_d = DONE;
                    end else begin
                        dir_d   = (cmd_if.CMD_OP == OP_INC);
                        state_d = SETUP;
                    end
                end
            end
            LOAD: begin
                cnt_d   = SETTLE_LAST;
                state_d = SETTLE;
            end
            SETUP: state_d = CHECK;
            CHECK: begin
                if (at_limit || oor_q) begin
                    oor_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    tap_d   = dir_q ? tap_q + 1'b1 : tap_q - 1'b1;
                    state_d = MOVE;
                end
            end
            MOVE: begin
                rem_d   = rem_q - 1'b1;
                cnt_d   = SETTLE_LAST;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    oor_d   = oor_q | oor_smp;
                    state_d = (rem_q == '0 || op_q == OP_LOAD) ? DONE : CHECK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they leave the flops glitch-free.
        move_d     = (state_d == MOVE);
        load_d     = (state_d == LOAD);
        done_d     = (state_d == DONE);
        done_oor_d = (state_d == DONE) && oor_d;
        ready_d    = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q    <= IDLE;
            op_q       <= OP_NOP;
            rem_q      <= '0;
            tap_q      <= LOAD_TAP_V;
            cnt_q      <= '0;
            dir_q      <= 1'b0;
            oor_q      <= 1'b0;
            move_q     <= 1'b0;
            load_q     <= 1'b0;
            done_q     <= 1'b0;
            done_oor_q <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values computed above.
            state_q    <= state_d;
            op_q       <= op_d;
            rem_q      <= rem_d;
            tap_q      <= tap_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            oor_q      <= oor_d;
            move_q     <= move_d;
            load_q     <= load_d;
            done_q     <= done_d;
            done_oor_q <= done_oor_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    assign cmd_if.CMD_READY     = ready_q;
    assign cmd_if.BUSY          = busy_q;
    assign cmd_if.DONE          = done_q;
    assign cmd_if.DONE_OOR      = done_oor_q;
    assign cmd_if.TAP_POS       = tap_q;
    assign DELAY_LINE_MOVE      = move_q;
    assign DELAY_LINE_LOAD      = load_q;
    assign DELAY_LINE_DIRECTION = dir_q;

endmodule

// File: tb/tb_iod_delay_line_ctrl.sv
// Self-checking bench for iod_delay_line_ctrl: directed and random commands scored
// against a step-count model of the tap sequencer.
module tb_iod_delay_line_ctrl;

    localparam int TAP_W    = 8;
    localparam int MAX_TAP  = 255;
    localparam int LOAD_TAP = 1;
    localparam int SETTLE   = 4;
`ifdef IOD_DLY_OOR_SYNC_EN
    localparam int S_EFF = SETTLE + 2;
`else
    localparam int S_EFF = SETTLE;
`endif
    localparam logic [1:0] C_NOP  = 2'b00;
    localparam logic [1:0] C_LOAD = 2'b01;
    localparam logic [1:0] C_INC  = 2'b10;
    localparam logic [1:0] C_DEC  = 2'b11;
    localparam int MAX_WAIT = 3000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic move, dir, load;
    logic oor_in = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int tap_model = LOAD_TAP;
    int obs_wait;

    iod_delay_line_ctrl_if #(.TAP_W(TAP_W)) bus ();

    iod_delay_line_ctrl #(
        .TAP_W(TAP_W), .MAX_TAP(MAX_TAP), .LOAD_TAP(LOAD_TAP), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .FAB_CLK                 (clk),
        .ARST_N                  (rst_n),
        .cmd_if                  (bus),
        .DELAY_LINE_MOVE         (move),
        .DELAY_LINE_DIRECTION    (dir),
        .DELAY_LINE_LOAD         (load),
        .DELAY_LINE_OUT_OF_RANGE (oor_in)
    );

    always #5 clk = ~clk;

    // Step-level model: how many taps can move before a range limit or the OOR flag stops it.
    function automatic void model(input logic [1:0] op, input int count, input int k,
                                  input int tap_in, output int e_moves, output int e_loads,
                                  output int e_lat, output int e_oor, output int e_tap);
        int avail;
        e_moves = 0; e_loads = 0; e_oor = 0; e_tap = tap_in; e_lat = 1;
        if (op == C_LOAD) begin
            e_loads = 1;
            e_lat   = 2 + S_EFF;
            e_tap   = LOAD_TAP;
        end else if (op != C_NOP && count > 0) begin
            avail   = (op == C_INC) ? MAX_TAP - tap_in : tap_in;
            e_moves = count;
            if (avail < e_moves) e_moves = avail;
            if (k > 0 && k < e_moves) e_moves = k;
            e_oor = (e_moves < count || (k > 0 && k == e_moves)) ? 1 : 0;
            e_lat = 1 + e_moves * (2 + S_EFF) + ((e_moves < count) ? 1 : 0) + 1;
            e_tap = (op == C_INC) ? tap_in + e_moves : tap_in - e_moves;
        end
    endfunction

    task automatic cmp(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Issue one command, watch the pins until DONE, then score against the model.
    task automatic run_cmd(input string tag, input logic [1:0] op, input int count,
                           input int k, input bit keep_valid);
        int cyc, n_moves, n_loads, load_cyc, last_move, bad_dir, bad_space, overlap, bad_hs;
        int lat, got_oor, got_tap;
        int e_moves, e_loads, e_lat, e_oor, e_tap;
        model(op, count, k, tap_model, e_moves, e_loads, e_lat, e_oor, e_tap);
        n_moves = 0; n_loads = 0; load_cyc = -1; last_move = -1;
        bad_dir = 0; bad_space = 0; overlap = 0; bad_hs = 0; lat = -1; got_oor = -1; got_tap = -1;

        @(negedge clk);
        bus.CMD_VALID = 1'b1;
        bus.CMD_OP    = op;
        bus.CMD_COUNT = TAP_W'(count);
        obs_wait = 0;
        while (bus.CMD_READY !== 1'b1 && obs_wait < MAX_WAIT) begin
            @(negedge clk);
            obs_wait++;
        end
        @(negedge clk);
        if (!keep_valid) bus.CMD_VALID = 1'b0;
        for (cyc = 1; cyc < MAX_WAIT; cyc++) begin
            if (move === 1'b1) begin
                n_moves++;
                if (dir !== (op == C_INC)) bad_dir++;
                if (last_move > 0 && cyc - last_move != 2 + S_EFF) bad_space++;
                last_move = cyc;
                if (n_moves == k) oor_in = 1'b1;
            end
            if (load === 1'b1) begin
                n_loads++;
                load_cyc = cyc;
            end
            if (move === 1'b1 && load === 1'b1) overlap++;
            if (bus.CMD_READY !== 1'b0 || bus.BUSY !== 1'b1) bad_hs++;
            if (bus.DONE === 1'b1) begin
                lat     = cyc;
                got_oor = int'(bus.DONE_OOR);
                got_tap = int'(bus.TAP_POS);
                break;
            end
            @(negedge clk);
        end
        oor_in = 1'b0;

        cmp({tag, " done_latency"}, lat, e_lat);
        cmp({tag, " move_pulses"}, n_moves, e_moves);
        cmp({tag, " load_pulses"}, n_loads, e_loads);
        cmp({tag, " done_oor"}, got_oor, e_oor);
        cmp({tag, " tap_pos"}, got_tap, e_tap);
        cmp({tag, " ready_busy_while_active"}, bad_hs, 0);
        if (e_moves > 0) begin
            cmp({tag, " direction"}, bad_dir, 0);
            cmp({tag, " move_spacing"}, bad_space, 0);
        end
        if (e_loads > 0) cmp({tag, " load_pulse_cycle"}, load_cyc, 1);
        cmp({tag, " move_load_overlap"}, overlap, 0);
        tap_model = e_tap;
    endtask

    task automatic test_reset();
        #12;
        cmp("reset CMD_READY", int'(bus.CMD_READY), 0);
        cmp("reset BUSY", int'(bus.BUSY), 0);
        cmp("reset DONE", int'(bus.DONE), 0);
        cmp("reset DONE_OOR", int'(bus.DONE_OOR), 0);
        cmp("reset MOVE", int'(move), 0);
        cmp("reset LOAD", int'(load), 0);
        cmp("reset DIRECTION", int'(dir), 0);
        cmp("reset TAP_POS", int'(bus.TAP_POS), LOAD_TAP);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        cmp("post_reset CMD_READY", int'(bus.CMD_READY), 1);
        cmp("post_reset BUSY", int'(bus.BUSY), 0);
        tap_model = LOAD_TAP;
    endtask

    task automatic test_load();
        run_cmd("load", C_LOAD, 0, 0, 1'b0);
    endtask

    task automatic test_inc();
        run_cmd("inc3", C_INC, 3, 0, 1'b0);
    endtask

    task automatic test_dec_limit();
        run_cmd("dec_to_2", C_DEC, tap_model - 2, 0, 1'b0);
        run_cmd("dec5_limit", C_DEC, 5, 0, 1'b0);
        run_cmd("dec_at_zero", C_DEC, 1, 0, 1'b0);
    endtask

    task automatic test_oor();
        run_cmd("inc10_oor", C_INC, 10, 4, 1'b0);
        run_cmd("inc2_oor_last", C_INC, 2, 2, 1'b0);
    endtask

    task automatic test_nop();
        run_cmd("nop", C_NOP, 7, 0, 1'b0);
        run_cmd("inc_count0", C_INC, 0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_cmd("b2b_inc", C_INC, 2, 0, 1'b1);
        run_cmd("b2b_nop", C_NOP, 0, 0, 1'b0);
        cmp("b2b accept_wait_after_done", obs_wait, 0);
    endtask

    task automatic test_max_limit();
        run_cmd("inc_to_max", C_INC, MAX_TAP, 0, 1'b0);
        run_cmd("inc_at_max", C_INC, 3, 0, 1'b0);
        run_cmd("dec_from_max", C_DEC, 2, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 14; i++) begin
            logic [1:0] op;
            int count, k;
            op    = 2'($urandom_range(0, 3));
            count = $urandom_range(0, 7);
            k     = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            run_cmd($sformatf("rand%0d", i), op, count, k, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        int seen, n;
        run_cmd("pre_mid_load", C_LOAD, 0, 0, 1'b0);
        @(negedge clk);
        bus.CMD_VALID = 1'b1;
        bus.CMD_OP    = C_INC;
        bus.CMD_COUNT = TAP_W'(5);
        @(negedge clk);
        bus.CMD_VALID = 1'b0;
        seen = 0;
        n = 0;
        while (seen < 2 && n < MAX_WAIT) begin
            if (move === 1'b1) seen++;
            if (seen < 2) @(negedge clk);
            n++;
        end
        cmp("mid second_pulse_seen", seen, 2);
        rst_n = 1'b0;
        #1;
        cmp("mid_reset MOVE", int'(move), 0);
        cmp("mid_reset BUSY", int'(bus.BUSY), 0);
        cmp("mid_reset CMD_READY", int'(bus.CMD_READY), 0);
        cmp("mid_reset TAP_POS", int'(bus.TAP_POS), LOAD_TAP);
        tap_model = LOAD_TAP;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        cmp("mid_release CMD_READY", int'(bus.CMD_READY), 1);
        run_cmd("post_mid_load", C_LOAD, 0, 0, 1'b0);
    endtask

    initial begin
        bus.CMD_VALID = 1'b0;
        bus.CMD_OP    = C_NOP;
        bus.CMD_COUNT = '0;
        test_reset();
        test_load();
        test_inc();
        test_dec_limit();
        test_oor();
        test_nop();
        test_back_to_back();
        test_max_limit();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
